// File: rtl/simple_array2d_drain.sv
// Streams a 2D array from a sync-read memory as 32-bit words: optional W/H header, then raster-order data.
// Header states exist only when SIMPLE_ARRAY2D_DRAIN_HEADER_EN is defined; data path buffers through a 2-entry FIFO.
module simple_array2d_drain #(
    parameter int ROW_WIDTH = 1,
    parameter int COL_WIDTH = 1,
    parameter int WORD_SIZE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_WIDTH-1:0] size_w,
    input  logic [COL_WIDTH-1:0] size_h,
    output logic                 re,
    output logic [ROW_WIDTH-1:0] raddrX,
    output logic [COL_WIDTH-1:0] raddrY,
    input  logic [WORD_SIZE-1:0] rdata,
    input  logic                 data_wanted,
    output logic                 data_ready,
    output logic [31:0]          data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_Idle,
        S_SendWidth,
        S_SendHeight,
        S_SendData,
        S_Done
    } state_t;

    state_t state, state_nxt;

    logic [ROW_WIDTH-1:0] size_w_q, x_q;
    logic [COL_WIDTH-1:0] size_h_q, y_q;
    logic                 addr_rem;
    logic                 inflight;
    logic [31:0]          fifo_mem [2];
    logic                 rptr, wptr;
    logic [1:0]           count;
    logic                 fifo_rd;
    logic [2:0]           occ;
    logic [ROW_WIDTH:0]   x_inc;
    logic [COL_WIDTH:0]   y_inc;
    logic                 last_addr;

    // Extra bit keeps a full-range width from wrapping before the compare.
    assign x_inc     = {1'b0, x_q} + {{ROW_WIDTH{1'b0}}, 1'b1};
    assign y_inc     = {1'b0, y_q} + {{COL_WIDTH{1'b0}}, 1'b1};
    assign last_addr = (x_inc == {1'b0, size_w_q}) && (y_inc == {1'b0, size_h_q});
    assign occ       = {1'b0, count} + {2'b00, inflight};
    assign raddrX    = (state == S_SendData) ? x_q : '0;
    assign raddrY    = (state == S_SendData) ? y_q : '0;

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_Idle);
        done       = (state == S_Done);
        data_ready = 1'b0;
        data       = '0;
        fifo_rd    = 1'b0;
        re         = 1'b0;
        case (state)
            S_Idle: begin
                if (start) begin
`ifdef SIMPLE_ARRAY2D_DRAIN_HEADER_EN
                    state_nxt = S_SendWidth;
`else
                    state_nxt = (size_w == '0 || size_h == '0) ? S_Done : S_SendData;
`endif
                end
            end
`ifdef SIMPLE_ARRAY2D_DRAIN_HEADER_EN
            S_SendWidth: begin
                data_ready = 1'b1;
                data       = 32'(size_w_q);
                if (data_wanted) state_nxt = S_SendHeight;
            end
            S_SendHeight: begin
                data_ready = 1'b1;
                data       = 32'(size_h_q);
                if (data_wanted)
                    state_nxt = (size_w_q == '0 || size_h_q == '0) ? S_Done : S_SendData;
            end
`endif
            S_SendData: begin
                data_ready = (count != 2'd0);
                data       = fifo_mem[rptr];
                fifo_rd    = data_ready && data_wanted;
                // A pop this cycle frees a slot for the read issued now.
                re         = addr_rem && (occ < (fifo_rd ? 3'd3 : 3'd2));
                if (!addr_rem && !inflight && count == 2'd1 && fifo_rd)
                    state_nxt = S_Done;
            end
            S_Done:  state_nxt = S_Idle;
            default: state_nxt = S_Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_Idle;
            size_w_q    <= '0;
            size_h_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_rem    <= 1'b0;
            inflight    <= 1'b0;
            rptr        <= 1'b0;
            wptr        <= 1'b0;
            count       <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= re;
            if (state == S_Idle && start) begin
                size_w_q <= size_w;
                size_h_q <= size_h;
                x_q      <= '0;
                y_q      <= '0;
                addr_rem <= (size_w != '0) && (size_h != '0);
            end
            if (re) begin
                if (last_addr) begin
                    addr_rem <= 1'b0;
                end else if (x_inc < {1'b0, size_w_q}) begin
                    x_q <= x_inc[ROW_WIDTH-1:0];
                end else begin
                    x_q <= '0;
                    y_q <= y_inc[COL_WIDTH-1:0];
                end
            end
            if (inflight) begin
                fifo_mem[wptr] <= 32'(rdata);
                wptr           <= ~wptr;
            end
            if (fifo_rd) rptr <= ~rptr;
            case ({inflight, fifo_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_array2d_drain.sv
// Scoreboard bench for simple_array2d_drain: raster-order reference model, random memory and stall patterns.
module tb_simple_array2d_drain;
    localparam int RW = 2;
    localparam int CW = 3;
    localparam int WS = 8;
`ifdef SIMPLE_ARRAY2D_DRAIN_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] size_w = '0;
    logic [CW-1:0] size_h = '0;
    logic          re;
    logic [RW-1:0] raddrX;
    logic [CW-1:0] raddrY;
    logic [WS-1:0] rdata = '0;
    logic          data_wanted = 1'b0;
    logic          data_ready;
    logic [31:0]   data;
    logic          busy;
    logic          done;

    simple_array2d_drain #(.ROW_WIDTH(RW), .COL_WIDTH(CW), .WORD_SIZE(WS)) dut (
        .clk(clk), .reset(reset), .start(start), .size_w(size_w), .size_h(size_h),
        .re(re), .raddrX(raddrX), .raddrY(raddrY), .rdata(rdata),
        .data_wanted(data_wanted), .data_ready(data_ready), .data(data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [WS-1:0] mem [0:7][0:3];
    always @(posedge clk) if (re) rdata <= mem[raddrY][raddrX];

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0]       exp_q[$];
    logic [RW+CW-1:0]  addr_q[$];
    int xfer_idx = 0, rd_out = 0, done_cnt = 0, stall_mode = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Consumer: always ready, 1-0-0 pattern, or random.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (stall_mode)
                0:       data_wanted = 1'b1;
                1:       begin data_wanted = (ph % 3 == 0); ph++; end
                default: data_wanted = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: word scoreboard, address order, stall stability, outstanding reads.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset && mon_en) begin
                if (prev_stall) begin
                    check("stall_ready_held", data_ready, 1);
                    check("stall_data_held", data, prev_data);
                end
                if (data_ready && data_wanted) begin
                    if (xfer_idx >= HDR) rd_out--;
                    xfer_idx++;
                    check("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("data_word", data, exp_q.pop_front());
                end
                if (re) begin
                    rd_out++;
                    check("read_expected", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) check("read_addr", {raddrY, raddrX}, addr_q.pop_front());
                    check("outstanding_le2", rd_out <= 2, 1);
                end
                if (done) done_cnt++;
                prev_stall = data_ready && !data_wanted;
                prev_data  = data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run_job(input int w, input int h, input int mode, input bit pattern,
                           input bit ign, input int abort_after);
        int first, done_at;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 4; x++)
                mem[y][x] = pattern ? WS'(16 * y + x) : WS'($urandom);
        exp_q.delete();
        addr_q.delete();
        if (HDR > 0) begin
            exp_q.push_back(32'(w));
            exp_q.push_back(32'(h));
        end
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                exp_q.push_back(32'(mem[y][x]));
                addr_q.push_back({CW'(y), RW'(x)});
            end
        xfer_idx = 0; rd_out = 0; done_cnt = 0; stall_mode = mode; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; size_w = RW'(w); size_h = CW'(h);
        first = -1; done_at = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ign && c == 2) begin start = 1'b1; size_w = 1; size_h = 1; end
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            if (first < 0 && data_ready) first = c;
            if (abort_after > 0 && xfer_idx >= abort_after) begin
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                @(negedge clk);
                check("rst_re", re, 0);
                check("rst_raddrX", raddrX, 0);
                check("rst_raddrY", raddrY, 0);
                check("rst_data_ready", data_ready, 0);
                check("rst_data", data, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                exp_q.delete();
                addr_q.delete();
                return;
            end
            if (done) begin done_at = c; break; end
        end
        check("done_seen", done_at > 0, 1);
        if (mode == 0) check("done_cycle", done_at, (w * h == 0) ? HDR + 1 : HDR + w * h + 3);
        if (HDR > 0 || w * h > 0) check("first_word_cycle", first, (HDR > 0) ? 1 : 3);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_pulses", done_cnt, 1);
        check("words_left", exp_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        check("re_idle", re, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_data_ready", data_ready, 0);
        check("reset_re", re, 0);
        check("reset_done", done, 0);
        check("reset_data", data, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_job(3, 2, 0, 1'b1, 1'b0, 0);
        run_job(3, 2, 1, 1'b1, 1'b0, 0);
        run_job(0, 5, 0, 1'b1, 1'b0, 0);
        run_job(3, 1, 0, 1'b1, 1'b0, 0);
        run_job(3, 2, 0, 1'b1, 1'b0, HDR + 2);
        run_job(3, 2, 0, 1'b1, 1'b0, 0);
        run_job(3, 7, 2, 1'b0, 1'b1, 0);
        run_job(2, 2, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            run_job($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2), 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
